// File: rtl/ctrl_poller.sv
// Serial game-pad poller: latches the pad, clocks out eight button bits with rd pulses,
// and publishes the completed byte on btns with valid/changed pulses.
module ctrl_poller #(
    parameter int LATCH_CYCLES    = 12,
    parameter int HALF_BIT_CYCLES = 6,
    parameter int POLL_INTERVAL   = 29830,
    parameter int DATA_INVERT     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       poll_req,
    output logic       strobe,
    output logic       rd,
    input  logic       data,
    output logic [7:0] btns,
    output logic       btns_valid,
    output logic       btns_changed,
    output logic       busy,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int PH_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int CNT_W  = $clog2(POLL_INTERVAL + 1);
    localparam logic [PH_W-1:0]  LATCH_LAST = PH_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0]  HALF_LAST  = PH_W'(HALF_BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(POLL_INTERVAL - 1);
    localparam logic             INV        = (DATA_INVERT != 0);

    state_t           state, next_state;
    logic [PH_W-1:0]  phase;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic [CNT_W-1:0] interval_cnt;
    logic             pending;
    logic             expiry;
    logic             start_poll;

    assign state_dbg  = state;
    assign expiry     = enable && (interval_cnt == '0);
    assign start_poll = (state == IDLE) && (pending || poll_req);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pending || poll_req) next_state = LATCH;
            LATCH:   if (phase == LATCH_LAST) next_state = LOW;
            LOW:     if (phase == HALF_LAST) next_state = HIGH;
            HIGH:    if (phase == HALF_LAST) next_state = (idx == 3'd7) ? DONE : LOW;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Pad outputs and status are flopped from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase        <= '0;
            idx          <= '0;
            shift        <= '0;
            strobe       <= 1'b0;
            rd           <= 1'b0;
            busy         <= 1'b0;
            btns         <= '0;
            btns_valid   <= 1'b0;
            btns_changed <= 1'b0;
        end else begin
            state      <= next_state;
            phase      <= (next_state != state) ? '0 : phase + 1'b1;
            strobe     <= (next_state == LATCH);
            rd         <= (next_state == HIGH);
            busy       <= (next_state != IDLE);
            btns_valid <= (next_state == DONE);
            btns_changed <= (next_state == DONE) && (shift != btns);
            if (next_state == DONE) btns <= shift;
            if (state == LATCH && next_state == LOW) idx <= '0;
            if (state == HIGH && next_state == LOW) idx <= idx + 3'd1;
            if (state == LOW && next_state == HIGH) shift[idx] <= data ^ INV;
        end
    end

    // A request that starts a poll consumes every same-cycle trigger, so they merge into one poll.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= 1'b0;
            interval_cnt <= CNT_RELOAD;
        end else begin
            if (start_poll) pending <= 1'b0;
            else if (expiry || (poll_req && busy)) pending <= 1'b1;

            if (!enable || interval_cnt == '0) interval_cnt <= CNT_RELOAD;
            else interval_cnt <= interval_cnt - 1'b1;
        end
    end

endmodule
